// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - writeback select, 32x32 register file and committed-write counter
// Optional macro WB_BYPASS_EN: same-cycle write-through to both read ports.
module wb_regfile #(
  parameter int COUNT_W = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         WB_i,
  input  logic [31:0]        data1_i,
  input  logic [31:0]        data2_i,
  input  logic [4:0]         RDaddr_i,
  input  logic [4:0]         RSaddr_i,
  input  logic [4:0]         RTaddr_i,
  output logic [31:0]        RSdata_o,
  output logic [31:0]        RTdata_o,
  output logic [31:0]        WBdata_o,
  output logic               RegWrite_o,
  output logic [4:0]         RDaddr_o,
  output logic [COUNT_W-1:0] wb_count_o
);

  logic [31:0]        regs_q [32];
  logic [31:0]        regs_d [32];
  logic [COUNT_W-1:0] cnt_q;
  logic [COUNT_W-1:0] cnt_d;
  logic               we;

  assign WBdata_o   = WB_i[0] ? data1_i : data2_i;
  assign we         = WB_i[1] && (RDaddr_i != 5'd0);
  assign RegWrite_o = we;
  assign RDaddr_o   = RDaddr_i;
  assign wb_count_o = cnt_q;

  always_comb begin
    regs_d = regs_q;
    cnt_d  = cnt_q;
    if (we) begin
      regs_d[RDaddr_i] = WBdata_o;
      cnt_d            = cnt_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
      cnt_q <= '0;
    end else begin
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  // x0 check is applied last so it overrides the bypass path.
  always_comb begin
    RSdata_o = regs_q[RSaddr_i];
    RTdata_o = regs_q[RTaddr_i];
`ifdef WB_BYPASS_EN
    if (we && (RSaddr_i == RDaddr_i)) RSdata_o = WBdata_o;
    if (we && (RTaddr_i == RDaddr_i)) RTdata_o = WBdata_o;
`endif
    if (RSaddr_i == 5'd0) RSdata_o = '0;
    if (RTaddr_i == 5'd0) RTdata_o = '0;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile against an array/counter reference model
module tb_wb_regfile;
  localparam int CW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [1:0]    WB_i = '0;
  logic [31:0]   data1_i = '0, data2_i = '0;
  logic [4:0]    RDaddr_i = '0, RSaddr_i = '0, RTaddr_i = '0;
  logic [31:0]   RSdata_o, RTdata_o, WBdata_o;
  logic          RegWrite_o;
  logic [4:0]    RDaddr_o;
  logic [CW-1:0] wb_count_o;

  wb_regfile #(.COUNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .data1_i(data1_i), .data2_i(data2_i),
    .RDaddr_i(RDaddr_i), .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
    .RSdata_o(RSdata_o), .RTdata_o(RTdata_o), .WBdata_o(WBdata_o),
    .RegWrite_o(RegWrite_o), .RDaddr_o(RDaddr_o), .wb_count_o(wb_count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   rs, rt, wbd;
    logic          regw;
    logic [4:0]    rd;
    logic [CW-1:0] cnt;
    int            idx;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int unsigned model_cnt = 0;
  int          checks = 0, errors = 0, issued = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s step %0d actual %h required %h", name, idx, act, req);
    end
  endtask

  // Apply one cycle of stimulus; expectations come from the model state before the next edge.
  task automatic step(input logic rst, input logic [1:0] wb, input logic [31:0] d1, input logic [31:0] d2,
                      input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    exp_t e;
    logic [31:0] wbd;
    logic we;
    @(posedge clk_i);
    #1;
    rst_i = rst; WB_i = wb; data1_i = d1; data2_i = d2; RDaddr_i = rd; RSaddr_i = rs; RTaddr_i = rt;
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model_cnt = 0;
    end
    wbd = wb[0] ? d1 : d2;
    we  = wb[1] && (rd != 0);
    e.wbd = wbd; e.regw = we; e.rd = rd; e.cnt = CW'(model_cnt % (1 << CW)); e.idx = issued;
    e.rs = model[rs];
    e.rt = model[rt];
`ifdef WB_BYPASS_EN
    if (we && rs == rd) e.rs = wbd;
    if (we && rt == rd) e.rt = wbd;
`endif
    if (rs == 0) e.rs = 32'd0;
    if (rt == 0) e.rt = 32'd0;
    sb.push_back(e);
    issued++;
    if (!rst && we) begin
      model[rd] = wbd;
      model_cnt++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("RSdata", e.idx, RSdata_o, e.rs);
        chk("RTdata", e.idx, RTdata_o, e.rt);
        chk("WBdata", e.idx, WBdata_o, e.wbd);
        chk("RegWrite", e.idx, {31'd0, RegWrite_o}, {31'd0, e.regw});
        chk("RDaddr", e.idx, {27'd0, RDaddr_o}, {27'd0, e.rd});
        chk("wb_count", e.idx, {{(32-CW){1'b0}}, wb_count_o}, {{(32-CW){1'b0}}, e.cnt});
      end
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    step(1, 2'b00, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0);
    // ALU writeback to r5, then read back
    step(0, 2'b10, 32'h0, 32'h1234_5678, 5, 0, 0);
    step(0, 2'b00, 0, 0, 0, 5, 0);
    // memory writeback to r31
    step(0, 2'b11, 32'hDEAD_BEEF, 32'h1, 31, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 31);
    // x0 protection
    step(0, 2'b10, 0, 32'hFFFF_FFFF, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0);
    // same-cycle read of a register being written
    step(0, 2'b10, 0, 32'hA, 7, 0, 0);
    step(0, 2'b10, 0, 32'hB, 7, 7, 7);
    step(0, 2'b00, 0, 0, 0, 7, 7);
    // reset asserted between edges with a write pending, then held across an edge
    step(0, 2'b00, 0, 0, 0, 5, 31);
    step(1, 2'b10, 0, 32'h55, 5, 5, 31);
    step(1, 2'b11, 32'h66, 0, 9, 9, 5);
    step(0, 2'b10, 0, 32'h77, 9, 9, 0);
    step(0, 2'b00, 0, 0, 0, 9, 5);
    // counter wrap: 16 writes to r1, then a non-write
    for (int i = 0; i < 16; i++) step(0, 2'b10, 0, 32'(i + 100), 1, 1, 2);
    step(0, 2'b01, 32'h9, 32'h8, 1, 1, 0);
    step(0, 2'b00, 0, 0, 0, 1, 0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      step(($urandom_range(0, 49) == 0), 2'($urandom), $urandom, $urandom, rd,
           ($urandom_range(0, 3) == 0) ? rd : 5'($urandom),
           ($urandom_range(0, 3) == 0) ? rd : 5'($urandom));
    end
    @(negedge clk_i);
    #1;
    chk("scoreboard_drained", issued, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback-stage consumer of the MEM/WB pipeline register. It selects between memory read data and ALU result using the registered WB control bits and commits the result to the 32×32-bit general-purpose register file. It serves the two ID-stage read ports and drives writeback data to the EX-stage forwarding unit. It also keeps a committed-write counter for debug and CPI measurement.

## Interface
Parameters:
- COUNT_W, 32, width of the committed-write counter

Ports:
- clk_i  in  1  pipeline clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-high reset
- WB_i  in  2  writeback control from MEM/WB; [1]=RegWrite, [0]=MemtoReg
- data1_i  in  32  memory read data from MEM/WB
- data2_i  in  32  ALU result from MEM/WB
- RDaddr_i  in  5  destination register from MEM/WB
- RSaddr_i  in  5  ID-stage read address, port A
- RTaddr_i  in  5  ID-stage read address, port B
- RSdata_o  out  32  read data, port A
- RTdata_o  out  32  read data, port B
- WBdata_o  out  32  selected writeback data, for the forwarding unit
- RegWrite_o  out  1  effective write enable (WB_i[1] and RDaddr_i≠0), for the forwarding unit
- RDaddr_o  out  5  RDaddr_i passed through, for the forwarding unit
- wb_count_o  out  COUNT_W  number of committed register writes

## Operation
- Writeback select (combinational): WBdata_o = WB_i[0] ? data1_i : data2_i.
- Write condition: we = WB_i[1] && (RDaddr_i != 5'd0). RegWrite_o = we.
- Register x0 is hardwired to zero:
  - Never written.
  - Reads of address 0 always return 32'd0, in every configuration.
- On a rising edge with we=1:
  - regs[RDaddr_i] ← WBdata_o.
  - wb_count_o ← wb_count_o + 1, modulo 2^COUNT_W. The counter wraps from all-ones to 0 silently.
- When we=0, the register array and the counter hold.
- Read ports are combinational from the array (plus bypass, see Configuration). Ports A and B are fully independent and may address the same register.
- Reset (rst_i=1, asynchronous):
  - All 32 registers clear to 0.
  - wb_count_o clears to 0.
  - While reset is held, writes are suppressed.
  - Reset asserted mid-write wins: the array and counter read 0 after the reset edge regardless of we.
- Combinational outputs track their inputs during reset. RSdata_o and RTdata_o read 0 because the array is cleared.

## Timing
- Write latency: 1 cycle. Data presented with we=1 before edge N is readable from the array after edge N.
- Read latency: 0 cycles (combinational).
- WBdata_o, RegWrite_o and RDaddr_o are combinational from the MEM/WB outputs, with no added delay.
- Counter updates on the same edge as the array write.
- Reset is asynchronous in assertion. Deassertion is sampled: the first write can occur on the first rising edge with rst_i=0.

## Configuration
- WB_BYPASS_EN defined: write-through bypass.
  - If we=1 and RSaddr_i==RDaddr_i, then RSdata_o = WBdata_o in the same cycle.
  - Likewise RTaddr_i==RDaddr_i gives RTdata_o = WBdata_o.
  - Removes the WB→ID read-after-write hazard without a stall.
- WB_BYPASS_EN undefined:
  - Read ports return the array contents only.
  - A same-cycle read of the register being written returns the old value.
  - The hazard-detection unit must stall for one cycle.
- The x0-reads-zero rule overrides the bypass in both configurations.

## Test plan
- Reset: preload several registers, assert rst_i between clock edges → all reads 0 and wb_count_o=0 immediately, without waiting for a clock edge.
- ALU writeback: WB_i=2'b10, data2_i=32'h1234_5678, RDaddr_i=5 for one edge, then RSaddr_i=5 → RSdata_o=32'h1234_5678, wb_count_o=1.
- Memory writeback: WB_i=2'b11, data1_i=32'hDEAD_BEEF, data2_i=32'h1, RDaddr_i=31 → WBdata_o=32'hDEAD_BEEF, and after the edge RTaddr_i=31 reads 32'hDEAD_BEEF.
- x0 protection: WB_i=2'b10, RDaddr_i=0, data2_i=32'hFFFF_FFFF → RegWrite_o=0, reads of address 0 return 0, wb_count_o unchanged.
- Same-cycle read/write: reg 7 holds 32'hA, then write 32'hB to reg 7 with RSaddr_i=7 before the edge → RSdata_o=32'hB with WB_BYPASS_EN defined, 32'hA without; 32'hB after the edge in both.
- Counter wrap: COUNT_W=4, 16 consecutive writes to reg 1 → wb_count_o returns to 0; a write with WB_i[1]=0 leaves it unchanged.
